// File: rtl/code_pkg.sv
// Shared types for the keypad code sender: key encodings, symbol type, FSM states.
package code_pkg;

  typedef logic [1:0] sym_t;

  localparam logic [3:0] KEY_A = 4'b0001;
  localparam logic [3:0] KEY_B = 4'b0010;
  localparam logic [3:0] KEY_C = 4'b0100;
  localparam logic [3:0] KEY_D = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    WAIT = 2'd3
  } state_e;

  // Symbol i of a packed 4-symbol code, symbol 0 in the low bits.
  function automatic sym_t get_sym(input logic [7:0] c, input logic [1:0] i);
    case (i)
      2'd0:    get_sym = c[1:0];
      2'd1:    get_sym = c[3:2];
      2'd2:    get_sym = c[5:4];
      default: get_sym = c[7:6];
    endcase
  endfunction

endpackage

// File: rtl/key_encoder.sv
// Combinational 2-bit symbol to one-hot key mapping.
module key_encoder
  import code_pkg::*;
(
  input  sym_t       sym,
  output logic [3:0] key
);

  always_comb begin
    key = '0;
    case (sym)
      2'd0:    key = KEY_A;
      2'd1:    key = KEY_B;
      2'd2:    key = KEY_C;
      default: key = KEY_D;
    endcase
  end

endmodule

// File: rtl/code_sender.sv
// Sends a 4-key code on a one-hot key bus, waits for unlock, retries on timeout.
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse qualifying pass/attempts.
module code_sender
  import code_pkg::*;
#(
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] code,
  input  logic [3:0] gap,
  input  logic       unlock,
  output logic [3:0] dout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] attempts
);

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  state_e     state, state_d;
  logic [1:0] idx, idx_d;
  logic [3:0] gap_cnt, gap_cnt_d;
  logic [7:0] tmo_cnt, tmo_cnt_d;
  logic [1:0] retry, retry_d;
  logic [7:0] code_q, code_d;
  logic [3:0] gap_q, gap_d;
  logic       finish, win;

  logic [3:0] key;
  logic [3:0] dout_d;
  logic       busy_d, done_d, pass_d;
  logic [1:0] attempts_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      retry    <= '0;
      code_q   <= '0;
      gap_q    <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      attempts <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      gap_cnt  <= gap_cnt_d;
      tmo_cnt  <= tmo_cnt_d;
      retry    <= retry_d;
      code_q   <= code_d;
      gap_q    <= gap_d;
      dout     <= dout_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      attempts <= attempts_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    gap_cnt_d = gap_cnt;
    tmo_cnt_d = tmo_cnt;
    retry_d   = retry;
    code_d    = code_q;
    gap_d     = gap_q;
    finish    = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          code_d  = code;
          gap_d   = gap;
          idx_d   = '0;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (idx == 2'd3) begin
          tmo_cnt_d = '0;
          state_d   = WAIT;
        end else if (gap_q == 4'd0) begin
          idx_d = idx + 2'd1;
        end else begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == gap_q - 4'd1) begin
          idx_d   = idx + 2'd1;
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt + 4'd1;
        end
      end
      WAIT: begin
        // unlock is checked first so it wins over an expiring timeout
        if (unlock) begin
          finish  = 1'b1;
          win     = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          if (retry < RETRY_MAX) begin
            retry_d = retry + 2'd1;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  key_encoder u_key_encoder (
    .sym (get_sym(code_d, idx_d)),
    .key (key)
  );

  // Outputs are computed from the next state so the registers line up with it.
  always_comb begin
    dout_d     = (state_d == SEND) ? key : 4'd0;
    busy_d     = (state_d != IDLE);
    done_d     = finish;
    pass_d     = win;
    attempts_d = finish ? retry : 2'd0;
  end

endmodule

// File: tb/tb_code_sender.sv
// Directed self-checking bench for code_sender with a per-cycle expected-key queue.
module tb_code_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] code;
  logic [3:0] gap;
  logic       unlock;
  logic [3:0] dout;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] attempts;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [3:0] exp_q[$];

  code_sender #(.TIMEOUT(8), .MAX_RETRY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .code     (code),
    .gap      (gap),
    .unlock   (unlock),
    .dout     (dout),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .attempts (attempts)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected dout stream of one full key sequence, then checks it cycle by cycle.
  task automatic seq_check(input logic [7:0] c, input logic [3:0] g,
                           input bit do_start, input bit noise);
    logic [3:0] e;
    logic [1:0] s;
    for (int i = 0; i < 4; i++) begin
      s = c[2*i +: 2];
      exp_q.push_back(4'b0001 << s);
      if (i < 3)
        for (int j = 0; j < g; j++) exp_q.push_back(4'b0000);
    end
    if (do_start) begin
      code  = c;
      gap   = g;
      start = 1'b1;
    end
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check("seq_dout", dout, e);
      check("seq_busy", busy, 1'b1);
      check("seq_done", done, 1'b0);
      if (noise) begin
        start  = 1'b1;
        unlock = 1'b1;
        code   = 8'($urandom_range(0, 255));
        gap    = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
    end
    start  = 1'b0;
    unlock = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("wait_dout", dout, 4'b0000);
      check("wait_busy", busy, 1'b1);
      check("wait_done", done, 1'b0);
    end
  endtask

  task automatic finish_check(input logic exp_pass, input logic [1:0] exp_att);
    tick();
    check("fin_done", done, 1'b1);
    check("fin_pass", pass, exp_pass);
    check("fin_att", attempts, exp_att);
    check("fin_busy", busy, 1'b0);
    check("fin_dout", dout, 4'b0000);
    unlock = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_dout", dout, 4'b0000);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; code = '0; gap = '0; unlock = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_att", attempts, 2'd0);
    rst = 1'b0;
    unlock = 1'b1;
    idle_check(2);
    unlock = 1'b0;

    // back-to-back keys, unlock on first WAIT cycle
    seq_check(8'b11_10_01_00, 4'd0, 1'b1, 1'b0);
    wait_idle(1);
    unlock = 1'b1;
    finish_check(1'b1, 2'd0);

    // start right after done, gap of 2
    seq_check(8'b11_10_01_00, 4'd2, 1'b1, 1'b0);
    wait_idle(3);
    unlock = 1'b1;
    finish_check(1'b1, 2'd0);
    idle_check(1);

    // never unlocked: three sequences then fail
    seq_check(8'b00_01_10_11, 4'd1, 1'b1, 1'b0);
    wait_idle(8);
    seq_check(8'b00_01_10_11, 4'd1, 1'b0, 1'b0);
    wait_idle(8);
    seq_check(8'b00_01_10_11, 4'd1, 1'b0, 1'b0);
    wait_idle(8);
    finish_check(1'b0, 2'd2);
    idle_check(2);

    // unlock in second attempt's WAIT, no third sequence
    seq_check(8'b01_11_00_10, 4'd0, 1'b1, 1'b0);
    wait_idle(8);
    seq_check(8'b01_11_00_10, 4'd0, 1'b0, 1'b0);
    wait_idle(2);
    unlock = 1'b1;
    finish_check(1'b1, 2'd1);
    idle_check(12);

    // unlock on the same cycle the timeout expires
    seq_check(8'b10_10_10_10, 4'd3, 1'b1, 1'b0);
    wait_idle(8);
    unlock = 1'b1;
    finish_check(1'b1, 2'd0);

    // reset after the second key
    code = 8'b11_10_01_00; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("r_key0", dout, 4'b0001);
    tick();
    check("r_key1", dout, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_dout", dout, 4'b0000);
    check("r_busy", busy, 1'b0);
    check("r_done", done, 1'b0);
    idle_check(3);

    // reset has priority over start
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rs_busy", busy, 1'b0);
    check("rs_dout", dout, 4'b0000);
    idle_check(2);

    seq_check(8'b01_00_11_10, 4'd0, 1'b1, 1'b0);
    wait_idle(4);
    unlock = 1'b1;
    finish_check(1'b1, 2'd0);

    // start/unlock/code/gap noise while busy; code 0 gives four A keys
    seq_check(8'h00, 4'd1, 1'b1, 1'b1);
    wait_idle(8);
    seq_check(8'h00, 4'd1, 1'b0, 1'b0);
    wait_idle(5);
    unlock = 1'b1;
    finish_check(1'b1, 2'd1);
    idle_check(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
